// File: rtl/digit_scan_controller_pkg.sv
// rtl/digit_scan_controller_pkg.sv - shared constants and types for the digit scan controller
// Holds the FSM state encoding, the digit count and the counter width helper.
package digit_scan_controller_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    // One counter serves both dwell and blank phases, so it must hold the larger terminal value.
    function automatic int cnt_width(input int prescale, input int blank_cyc);
        int w;
        w = ($clog2(prescale) > $clog2(blank_cyc)) ? $clog2(prescale) : $clog2(blank_cyc);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/digit_scan_controller_if.sv
// rtl/digit_scan_controller_if.sv - scan controller signal bundle
// Ports (via modports):
//   run, digit_mask, nibble_in          : control and digit data into the controller
//   sel, sel_en, nibble_out, frame_done : decoder select/enable, current nibble, wrap pulse
interface digit_scan_controller_if import digit_scan_controller_pkg::*; ();

    logic                        run;
    logic [NUM_DIGITS-1:0]       digit_mask;
    logic [4*NUM_DIGITS-1:0]     nibble_in;
    logic [1:0]                  sel;
    logic                        sel_en;
    logic [3:0]                  nibble_out;
    logic                        frame_done;

    // master drives the controls and observes the scan outputs
    modport master (
        output run, digit_mask, nibble_in,
        input  sel, sel_en, nibble_out, frame_done
    );

    // slave is the scan controller itself
    modport slave (
        input  run, digit_mask, nibble_in,
        output sel, sel_en, nibble_out, frame_done
    );

endinterface

// File: rtl/digit_scan_controller_next_digit_pick.sv
// rtl/digit_scan_controller_next_digit_pick.sv - combinational next-enabled-digit search
// Ports:
//   cur  : current digit index
//   mask : participating digits
//   nxt  : first set mask bit searched from cur+1 upward with wrap
//   wrap : nxt <= cur, i.e. the search wrapped past digit 3
//   none : mask is empty
module next_digit_pick
    import digit_scan_controller_pkg::*;
(
    input  logic [1:0]            cur,
    input  logic [NUM_DIGITS-1:0] mask,
    output logic [1:0]            nxt,
    output logic                  wrap,
    output logic                  none
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        nxt   = cur;
        idx   = '0;
        found = 1'b0;
        // k = 4 revisits cur itself, which covers the single-digit mask case
        for (int k = 1; k <= NUM_DIGITS; k++) begin
            idx = cur + 2'(k);
            if (!found && mask[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
        none = (mask == '0);
        wrap = !none && (nxt <= cur);
    end

endmodule

// File: rtl/digit_scan_controller.sv
// rtl/digit_scan_controller.sv - blanked time-multiplexing digit scan controller
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of digit_scan_controller_if (run, digit_mask, nibble_in in;
//           sel, sel_en, nibble_out, frame_done out, all registered)
// Parameters:
//   PRESCALE  : cycles a digit stays enabled (>= 1)
//   BLANK_CYC : cycles enable stays low between digits (>= 1)
module digit_scan_controller
    import digit_scan_controller_pkg::*;
#(
    parameter int PRESCALE  = 100000,
    parameter int BLANK_CYC = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    digit_scan_controller_if.slave   bus
);

    localparam int CNT_W = cnt_width(PRESCALE, BLANK_CYC);

    state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]   sel_r;
    logic         sel_en_r;
    logic [3:0]   nibble_r;
    logic         frame_done_r;

    logic [1:0]   pick_cur;
    logic [1:0]   pick_nxt;
    logic         pick_wrap;
    logic         pick_none;

    // Seeding the search with 3 from IDLE makes it start at digit 0, which yields the
    // lowest set bit; this lets one picker serve both entry and advance.
    assign pick_cur = (state == ST_IDLE) ? 2'd3 : sel_r;

    next_digit_pick u_pick (
        .cur  (pick_cur),
        .mask (bus.digit_mask),
        .nxt  (pick_nxt),
        .wrap (pick_wrap),
        .none (pick_none)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            sel_r        <= 2'd0;
            sel_en_r     <= 1'b0;
            nibble_r     <= 4'd0;
            frame_done_r <= 1'b0;
        end else begin
            // Tracks live data for the registered sel; settles during BLANK after a sel change.
            nibble_r     <= bus.nibble_in[{sel_r, 2'b00} +: 4];
            frame_done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    sel_en_r <= 1'b0;
                    cnt      <= '0;
                    if (bus.run && !pick_none) begin
                        state    <= ST_SHOW;
                        sel_r    <= pick_nxt;
                        sel_en_r <= 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (!bus.run) begin
                        state    <= ST_IDLE;
                        sel_en_r <= 1'b0;
                        cnt      <= '0;
                    end else if (cnt == CNT_W'(PRESCALE - 1)) begin
                        cnt      <= '0;
                        sel_en_r <= 1'b0;
                        if (pick_none) begin
                            state <= ST_IDLE;
                        end else begin
                            // sel moves while enable drops, so the decoder never sees it change enabled
                            state        <= ST_BLANK;
                            sel_r        <= pick_nxt;
                            frame_done_r <= pick_wrap;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (!bus.run) begin
                        state    <= ST_IDLE;
                        sel_en_r <= 1'b0;
                        cnt      <= '0;
                    end else if (cnt == CNT_W'(BLANK_CYC - 1)) begin
                        state    <= ST_SHOW;
                        sel_en_r <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    sel_en_r <= 1'b0;
                    cnt      <= '0;
                end
            endcase
        end
    end

    assign bus.sel        = sel_r;
    assign bus.sel_en     = sel_en_r;
    assign bus.nibble_out = nibble_r;
    assign bus.frame_done = frame_done_r;

endmodule
